seq_mult_add: RTL

//   Sequential shift-and-add multiplier-accumulator: computes result = Q*D + R.

---
 rtl/seq_mult_add.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seq_mult_add.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : seq_mult_add                                                |
// | Purpose  : Shift-and-add multiply-accumulate, result = Q*D + R, one    |
// |            multiplier bit per clock. Optional macro REMAINDER_CHECK_EN |
// |            enables the err flag (R >= D).                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module seq_mult_add #(
  parameter int WIDTH = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 go,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_REL = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_ADD_REM  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (go)                 state_d = S_WAIT_REL;
      S_WAIT_REL: if (!go)                state_d = S_RUN;
      S_RUN:      if (count_q == C_LAST)  state_d = S_ADD_REM;
      S_ADD_REM:                          state_d = S_DONE;
      S_DONE:                             state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath next-state; operands track the inputs only while idle
  always_comb begin
    q_d      = q_q;
    d_d      = d_q;
    r_d      = r_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        q_d     = quotient;
        d_d     = divisor;
        r_d     = remainder;
        acc_d   = '0;
        count_d = '0;
      end
      S_RUN: begin
        if (q_q[0]) acc_d = acc_q + ({{WIDTH{1'b0}}, d_q} << count_q);
        q_d     = q_q >> 1;
        count_d = count_q + CW'(1);
      end
      S_ADD_REM: begin
        acc_d = acc_q + {{WIDTH{1'b0}}, r_q};
      end
      S_DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
`ifdef REMAINDER_CHECK_EN
        err_d    = (r_q >= d_q);
`else
        err_d    = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      q_q      <= '0;
      d_q      <= '0;
      r_q      <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      d_q      <= d_d;
      r_q      <= r_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
`default_nettype wire
